ad_lvds_rx_deframe: RTL and testbench

//  Consumes the AD9361 LVDS receive bus in the domain of the buffered data clock, after IDDR

---
 rtl/ad_lvds_rx_deframe.sv | 216 +++++++++++++++++++++
 tb/tb_ad_lvds_rx_deframe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_lvds_rx_deframe.sv
// rtl/ad_lvds_rx_deframe.sv - AD9361 LVDS receive deframer: FRAME-based half-cycle alignment,
// 12-bit I/Q sample rebuild for 1R1T/2R2T, lock tracking and saturating framing-error count.
`timescale 1ns/1ps
module ad_lvds_rx_deframe #(
  parameter int LOCK_COUNT    = 4,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode_1r1t,
  input  logic                     rx_frame_p,
  input  logic                     rx_frame_n,
  input  logic [5:0]               rx_data_p,
  input  logic [5:0]               rx_data_n,
  output logic                     adc_valid,
  output logic [11:0]              adc_data_i0,
  output logic [11:0]              adc_data_q0,
  output logic [11:0]              adc_data_i1,
  output logic [11:0]              adc_data_q1,
  output logic                     adc_locked,
  output logic                     adc_frame_err,
  output logic [ERR_CNT_WIDTH-1:0] adc_err_cnt
);

  localparam int CW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {ST_SEEK = 2'd0, ST_ALIGN = 2'd1, ST_LOCK = 2'd2} state_t;

  logic [5:0] d_p_q, d_n_q, d_n_prev;
  logic       f_p_q, f_n_q, f_n_prev;
  logic       mode_q;
  logic [1:0] frame_prev;
  logic [2:0] pos_q, pos;
  logic [5:0] hi0_i, hi0_q, lo0_i, lo0_q, hi1_i, hi1_q;

  state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic       mis_q, mis_d;
  logic       phase_sel, phase_d;

  logic       f_first, f_second;
  logic [5:0] d_first, d_second;
  logic [1:0] frame_word, exp_word;
  logic [2:0] period_len, half_len;
  logic       restart, clk_good, period_end, misaligned, mode_change;
  logic       valid_c, err_c;
  logic [11:0] smp_i0, smp_q0, smp_i1, smp_q1;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_p_q      <= '0;
      d_n_q      <= '0;
      d_n_prev   <= '0;
      f_p_q      <= 1'b0;
      f_n_q      <= 1'b0;
      f_n_prev   <= 1'b0;
      mode_q     <= 1'b0;
      frame_prev <= 2'b00;
      pos_q      <= 3'd0;
      hi0_i      <= '0;
      hi0_q      <= '0;
      lo0_i      <= '0;
      lo0_q      <= '0;
      hi1_i      <= '0;
      hi1_q      <= '0;
    end else begin
      d_p_q      <= rx_data_p;
      d_n_q      <= rx_data_n;
      d_n_prev   <= d_n_q;
      f_p_q      <= rx_frame_p;
      f_n_q      <= rx_frame_n;
      f_n_prev   <= f_n_q;
      mode_q     <= mode_1r1t;
      frame_prev <= frame_word;
      pos_q      <= pos;
      case (pos)
        3'd0: begin hi0_i <= d_first; hi0_q <= d_second; end
        3'd1: begin lo0_i <= d_first; lo0_q <= d_second; end
        3'd2: begin hi1_i <= d_first; hi1_q <= d_second; end
        default: ;
      endcase
    end
  end

  // phase_sel=1 pairs the previous falling nibble with the current rising one
  assign f_first    = phase_sel ? f_n_prev : f_p_q;
  assign f_second   = phase_sel ? f_p_q    : f_n_q;
  assign d_first    = phase_sel ? d_n_prev : d_p_q;
  assign d_second   = phase_sel ? d_p_q    : d_n_q;
  assign frame_word = {f_first, f_second};
  assign misaligned = f_first != f_second;
  assign restart    = (frame_word == 2'b11) && (frame_prev == 2'b00);
  assign mode_change = mode_1r1t != mode_q;

  assign period_len = mode_q ? 3'd2 : 3'd4;
  assign half_len   = mode_q ? 3'd1 : 3'd2;

  always_comb begin
    pos = pos_q;
    if (restart) pos = 3'd0;
    else if (pos_q != 3'd7) pos = pos_q + 3'd1;
  end

  assign exp_word   = (pos < half_len) ? 2'b11 : 2'b00;
  assign clk_good   = (pos < period_len) && (frame_word == exp_word);
  assign period_end = clk_good && (pos == period_len - 3'd1);

  always_comb begin
    if (mode_q) begin
      smp_i0 = {hi0_i, d_first};
      smp_q0 = {hi0_q, d_second};
      smp_i1 = 12'h000;
      smp_q1 = 12'h000;
    end else begin
      smp_i0 = {hi0_i, lo0_i};
      smp_q0 = {hi0_q, lo0_q};
      smp_i1 = {hi1_i, d_first};
      smp_q1 = {hi1_q, d_second};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_SEEK;
      cnt_q     <= '0;
      mis_q     <= 1'b0;
      phase_sel <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mis_q     <= mis_d;
      phase_sel <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    phase_d = phase_sel;
    if (mode_change) begin
      state_d = ST_SEEK;
      cnt_d   = '0;
      mis_d   = 1'b0;
    end else begin
      case (state_q)
        ST_SEEK: begin
          if (restart) begin
            state_d = ST_ALIGN;
            cnt_d   = CW'(1);
            mis_d   = 1'b0;
          end else if (misaligned) begin
            if (mis_q) begin
              phase_d = ~phase_sel;
              mis_d   = 1'b0;
            end else begin
              mis_d   = 1'b1;
            end
          end
        end
        ST_ALIGN: begin
          if (!clk_good) begin
            state_d = ST_SEEK;
            cnt_d   = '0;
          end else if (period_end) begin
            if (int'(cnt_q) + 1 >= LOCK_COUNT) begin
              state_d = ST_LOCK;
              cnt_d   = '0;
            end else begin
              cnt_d   = cnt_q + CW'(1);
            end
          end
        end
        ST_LOCK: begin
          if (!clk_good) begin
            state_d = ST_SEEK;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_SEEK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    adc_locked = (state_q == ST_LOCK);
    valid_c    = (state_q == ST_LOCK) && period_end && !mode_change;
    err_c      = (state_q == ST_LOCK) && !clk_good && !mode_change;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      adc_valid     <= 1'b0;
      adc_data_i0   <= '0;
      adc_data_q0   <= '0;
      adc_data_i1   <= '0;
      adc_data_q1   <= '0;
      adc_frame_err <= 1'b0;
      adc_err_cnt   <= '0;
    end else begin
      adc_valid     <= valid_c;
      adc_frame_err <= err_c;
      if (valid_c) begin
        adc_data_i0 <= smp_i0;
        adc_data_q0 <= smp_q0;
        adc_data_i1 <= smp_i1;
        adc_data_q1 <= smp_q1;
      end
      if (err_c && !(&adc_err_cnt)) adc_err_cnt <= adc_err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ad_lvds_rx_deframe.sv
// tb/tb_ad_lvds_rx_deframe.sv - randomized self-checking bench for ad_lvds_rx_deframe
// against a sample-level stream model and a latency-indexed scoreboard.
`timescale 1ns/1ps
module tb_ad_lvds_rx_deframe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, mode_1r1t, rx_frame_p, rx_frame_n;
  logic [5:0] rx_data_p, rx_data_n;
  logic adc_valid, adc_locked, adc_frame_err;
  logic [11:0] adc_data_i0, adc_data_q0, adc_data_i1, adc_data_q1;
  logic [15:0] adc_err_cnt;
  logic s_valid, s_locked, s_frame_err;
  logic [11:0] s_i0, s_q0, s_i1, s_q1;
  logic [1:0] s_err_cnt;

  ad_lvds_rx_deframe dut (
    .clk(clk), .rst(rst), .mode_1r1t(mode_1r1t),
    .rx_frame_p(rx_frame_p), .rx_frame_n(rx_frame_n),
    .rx_data_p(rx_data_p), .rx_data_n(rx_data_n),
    .adc_valid(adc_valid), .adc_data_i0(adc_data_i0), .adc_data_q0(adc_data_q0),
    .adc_data_i1(adc_data_i1), .adc_data_q1(adc_data_q1),
    .adc_locked(adc_locked), .adc_frame_err(adc_frame_err), .adc_err_cnt(adc_err_cnt)
  );

  ad_lvds_rx_deframe #(.LOCK_COUNT(4), .ERR_CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .mode_1r1t(mode_1r1t),
    .rx_frame_p(rx_frame_p), .rx_frame_n(rx_frame_n),
    .rx_data_p(rx_data_p), .rx_data_n(rx_data_n),
    .adc_valid(s_valid), .adc_data_i0(s_i0), .adc_data_q0(s_q0),
    .adc_data_i1(s_i1), .adc_data_q1(s_q1),
    .adc_locked(s_locked), .adc_frame_err(s_frame_err), .adc_err_cnt(s_err_cnt)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // expected sample set indexed by the cycle its valid strobe must appear
  logic        exp_v  [16384];
  logic [11:0] exp_i0 [16384];
  logic [11:0] exp_q0 [16384];
  logic [11:0] exp_i1 [16384];
  logic [11:0] exp_q1 [16384];

  int phase = 0;
  logic mode_v = 1'b1;
  int mode_arm = 0;
  int exp_errs = 0;
  int err_pulses = 0;
  int win_lo = 0, win_hi = 0, win_cnt = 0;
  logic use_fix = 1'b1;
  logic [11:0] fix_i0, fix_q0, fix_i1, fix_q1;

  logic pf, p_last;
  logic [5:0] pb;
  logic [11:0] p_i0, p_q0, p_i1, p_q1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (adc_frame_err) err_pulses++;
    if (adc_valid) begin
      chk("valid_slot", {31'd0, exp_v[cyc]}, 32'd1);
      if (exp_v[cyc]) begin
        chk("i0", {20'd0, adc_data_i0}, {20'd0, exp_i0[cyc]});
        chk("q0", {20'd0, adc_data_q0}, {20'd0, exp_q0[cyc]});
        chk("i1", {20'd0, adc_data_i1}, {20'd0, exp_i1[cyc]});
        chk("q1", {20'd0, adc_data_q1}, {20'd0, exp_q1[cyc]});
      end
      if (cyc >= win_lo && cyc < win_hi) win_cnt++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic mark(input int c, input logic [11:0] i0, q0, i1, q1);
    if (c < 16384) begin
      exp_v[c] = 1'b1; exp_i0[c] = i0; exp_q0[c] = q0; exp_i1[c] = i1; exp_q1[c] = q1;
    end
  endtask

  task automatic drive_pair(input logic f, input logic [5:0] a, input logic [5:0] b,
                            input logic last, input logic [11:0] i0, q0, i1, q1,
                            input logic bad);
    logic fe;
    tick();
    if (mode_arm == 2) begin
      @(negedge clk);
      chk("toggle_unlock", {31'd0, adc_locked}, 32'd0);
      chk("toggle_no_err", {31'd0, adc_frame_err}, 32'd0);
      chk("toggle_cnt_held", {16'd0, adc_err_cnt}, exp_errs);
      mode_arm = 0;
    end
    mode_1r1t = mode_v;
    fe = bad ? ~f : f;
    if (phase == 0) begin
      rx_frame_p = fe; rx_frame_n = fe; rx_data_p = a; rx_data_n = b;
      if (last) mark(cyc + 2, i0, q0, i1, q1);
    end else begin
      rx_frame_p = pf; rx_data_p = pb; rx_frame_n = fe; rx_data_n = a;
      if (p_last) mark(cyc + 2, p_i0, p_q0, p_i1, p_q1);
      pf = fe; pb = b; p_last = last;
      p_i0 = i0; p_q0 = q0; p_i1 = i1; p_q1 = q1;
    end
    if (mode_arm == 1) mode_arm = 2;
  endtask

  task automatic send_period(input logic [11:0] i0, q0, i1, q1, input logic bad);
    if (mode_v) begin
      drive_pair(1'b1, i0[11:6], q0[11:6], 1'b0, i0, q0, 12'h0, 12'h0, bad);
      drive_pair(1'b0, i0[5:0],  q0[5:0],  1'b1, i0, q0, 12'h0, 12'h0, 1'b0);
    end else begin
      drive_pair(1'b1, i0[11:6], q0[11:6], 1'b0, i0, q0, i1, q1, bad);
      drive_pair(1'b1, i0[5:0],  q0[5:0],  1'b0, i0, q0, i1, q1, 1'b0);
      drive_pair(1'b0, i1[11:6], q1[11:6], 1'b0, i0, q0, i1, q1, 1'b0);
      drive_pair(1'b0, i1[5:0],  q1[5:0],  1'b1, i0, q0, i1, q1, 1'b0);
    end
  endtask

  task automatic next_period(input logic bad);
    logic [11:0] r0, r1, r2, r3;
    if (use_fix) send_period(fix_i0, fix_q0, fix_i1, fix_q1, bad);
    else begin
      r0 = 12'($urandom); r1 = 12'($urandom); r2 = 12'($urandom); r3 = 12'($urandom);
      send_period(r0, r1, r2, r3, bad);
    end
  endtask

  task automatic wait_lock(input string tag);
    int k = 0;
    do begin
      next_period(1'b0);
      k++;
    end while (!adc_locked && k < 40);
    chk(tag, {31'd0, adc_locked}, 32'd1);
    next_period(1'b0);
  endtask

  task automatic valid_window(input string tag, input int n);
    int p;
    p = mode_v ? 2 : 4;
    win_cnt = 0;
    win_lo = cyc + 3;
    win_hi = cyc + n * p + 3;
    repeat (n + 2) next_period(1'b0);
    chk(tag, win_cnt, n);
  endtask

  task automatic do_reset;
    tick();
    rst = 1'b1;
    mode_1r1t = mode_v;
    rx_frame_p = 1'b0; rx_frame_n = 1'b0; rx_data_p = '0; rx_data_n = '0;
    pf = 1'b0; pb = '0; p_last = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'd0, adc_valid}, 32'd0);
    chk("rst_i0", {20'd0, adc_data_i0}, 32'd0);
    chk("rst_q0", {20'd0, adc_data_q0}, 32'd0);
    chk("rst_i1", {20'd0, adc_data_i1}, 32'd0);
    chk("rst_q1", {20'd0, adc_data_q1}, 32'd0);
    chk("rst_locked", {31'd0, adc_locked}, 32'd0);
    chk("rst_err", {31'd0, adc_frame_err}, 32'd0);
    chk("rst_err_cnt", {16'd0, adc_err_cnt}, 32'd0);
    chk("rst_sat_cnt", {30'd0, s_err_cnt}, 32'd0);
    exp_errs = 0;
  endtask

  initial begin
    int pulses0;
    for (int i = 0; i < 16384; i++) exp_v[i] = 1'b0;
    rst = 1'b1; mode_1r1t = 1'b1;
    rx_frame_p = 1'b0; rx_frame_n = 1'b0; rx_data_p = '0; rx_data_n = '0;
    pf = 1'b0; pb = '0; p_last = 1'b0;
    p_i0 = '0; p_q0 = '0; p_i1 = '0; p_q1 = '0;
    repeat (3) @(posedge clk);

    // 1R1T, phase 0, fixed sample then random samples
    phase = 0; mode_v = 1'b1;
    do_reset();
    use_fix = 1'b1; fix_i0 = 12'hA5C; fix_q0 = 12'h3F1; fix_i1 = 12'h0; fix_q1 = 12'h0;
    wait_lock("t1_lock");
    valid_window("t1_valid_rate", 8);
    use_fix = 1'b0;
    repeat (6) next_period(1'b0);

    // switch to 2R2T while locked
    chk("t2_pre_lock", {31'd0, adc_locked}, 32'd1);
    mode_v = 1'b0; mode_arm = 1;
    use_fix = 1'b1; fix_i0 = 12'h123; fix_q0 = 12'h456; fix_i1 = 12'h789; fix_q1 = 12'hABC;
    wait_lock("t2_lock");
    valid_window("t2_valid_rate", 6);
    use_fix = 1'b0;
    repeat (6) next_period(1'b0);

    // reset mid-stream, then half-cycle shifted 1R1T stream
    mode_v = 1'b1; phase = 1;
    do_reset();
    use_fix = 1'b1; fix_i0 = 12'hA5C; fix_q0 = 12'h3F1; fix_i1 = 12'h0; fix_q1 = 12'h0;
    wait_lock("t3_lock");
    valid_window("t3_valid_rate", 6);

    // framing errors while locked; the 2-bit counter saturates at 3
    use_fix = 1'b0;
    for (int e = 0; e < 5; e++) begin
      pulses0 = err_pulses;
      next_period(1'b1);
      next_period(1'b0);
      next_period(1'b0);
      exp_errs++;
      chk("err_unlock", {31'd0, adc_locked}, 32'd0);
      chk("err_pulse_once", err_pulses - pulses0, 1);
      chk("err_cnt", {16'd0, adc_err_cnt}, exp_errs);
      chk("sat_cnt", {30'd0, s_err_cnt}, (exp_errs > 3) ? 3 : exp_errs);
      wait_lock("err_relock");
    end

    // mode toggle while locked: no error, counter held, relock in 2R2T
    pulses0 = err_pulses;
    chk("t6_pre_lock", {31'd0, adc_locked}, 32'd1);
    mode_v = 1'b0; mode_arm = 1;
    wait_lock("t6_lock");
    valid_window("t6_valid_rate", 6);
    chk("t6_no_pulse", err_pulses - pulses0, 0);
    chk("t6_err_cnt", {16'd0, adc_err_cnt}, 5);
    chk("t6_sat_cnt", {30'd0, s_err_cnt}, 3);

    do_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
